// File: rtl/spi_wb_bridge_if.sv
// rtl/spi_wb_bridge_if.sv - Wishbone B4 pipelined bus bundle between the SPI bridge and its peripherals
interface spi_wb_bridge_if #(
    parameter int WB_ADDR_WIDTH = 17,
    parameter int DATA_WIDTH    = 8
);
    logic [WB_ADDR_WIDTH-1:0] wb_addr_o;
    logic [DATA_WIDTH-1:0]    wb_data_o;
    logic [DATA_WIDTH-1:0]    wb_data_i;
    logic                     wb_we_o;
    logic                     wb_cycle_o;
    logic                     wb_strobe_o;
    logic                     wb_stall_i;
    logic                     wb_ack_i;

    modport master (
        output wb_addr_o, wb_data_o, wb_we_o, wb_cycle_o, wb_strobe_o,
        input  wb_data_i, wb_stall_i, wb_ack_i
    );

    modport slave (
        input  wb_addr_o, wb_data_o, wb_we_o, wb_cycle_o, wb_strobe_o,
        output wb_data_i, wb_stall_i, wb_ack_i
    );
endinterface

// File: rtl/spi_wb_bridge.sv
// rtl/spi_wb_bridge.sv - SPI mode-0 target issuing single Wishbone B4 pipelined cycles
// Optional ack timeout and sticky status: define SPI_WB_TIMEOUT_EN.
module spi_wb_bridge #(
    parameter int WB_ADDR_WIDTH = 17,
    parameter int DATA_WIDTH    = 8
) (
    input  logic            wb_clock_i,
    input  logic            wb_reset_n_i,
    input  logic            spi_sck_i,
    input  logic            spi_cs_ni,
    input  logic            spi_pico_i,
    output logic            spi_poci_o,
    output logic            busy_o,
    spi_wb_bridge_if.master wb
);
    typedef enum logic [2:0] {
        S_CMD, S_ADDR_HI, S_ADDR_LO, S_DATA, S_WB_REQ, S_WB_WAIT
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               sck_q, sck_d;
    logic [1:0]               cs_q, cs_d;
    logic [1:0]               pico_q, pico_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [7:0]               rx_q, rx_d;
    logic [DATA_WIDTH-1:0]    tx_q, tx_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                     we_q, we_d;
    logic                     poci_q, poci_d;
`ifdef SPI_WB_TIMEOUT_EN
    logic [5:0]               to_cnt_q, to_cnt_d;
    logic                     to_flag_q, to_flag_d;
`endif

    logic       sck_rise, cs_high, byte_done, wb_active, tx_bit;
    logic [7:0] byte_val;

    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign cs_high   = cs_q[1];
    assign byte_val  = {rx_q[6:0], pico_q[1]};
    assign wb_active = (state_q == S_WB_REQ) || (state_q == S_WB_WAIT);

    always_comb begin
        state_d   = state_q;
        sck_d     = {sck_q[1:0], spi_sck_i};
        cs_d      = {cs_q[0], spi_cs_ni};
        pico_d    = {pico_q[0], spi_pico_i};
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        data_d    = data_q;
        addr_d    = addr_q;
        we_d      = we_q;
        byte_done = 1'b0;
`ifdef SPI_WB_TIMEOUT_EN
        to_cnt_d  = wb_active ? to_cnt_q + 6'd1 : 6'd0;
        to_flag_d = to_flag_q;
`endif

        if (cs_high) begin
            bit_cnt_d = 3'd0;
        end else if (sck_rise) begin
            rx_d      = byte_val;
            bit_cnt_d = bit_cnt_q + 3'd1;
            byte_done = (bit_cnt_q == 3'd7);
        end

        case (state_q)
            S_CMD: if (byte_done) begin
                we_d = ~byte_val[6];
                if (!byte_val[7]) begin
                    addr_d[16] = byte_val[0];
                    state_d    = S_ADDR_HI;
                end else begin
                    // streaming ops ignore A16 and just advance the persistent address
                    addr_d  = addr_q + WB_ADDR_WIDTH'(1);
                    state_d = byte_val[6] ? S_WB_REQ : S_DATA;
                end
            end
            S_ADDR_HI: if (byte_done) begin
                addr_d[15:8] = byte_val;
                state_d      = S_ADDR_LO;
            end
            S_ADDR_LO: if (byte_done) begin
                addr_d[7:0] = byte_val;
                state_d     = we_q ? S_DATA : S_WB_REQ;
            end
            S_DATA: if (byte_done) begin
                data_d  = byte_val;
                state_d = S_WB_REQ;
            end
            S_WB_REQ: if (!wb.wb_stall_i) begin
                state_d = wb.wb_ack_i ? S_CMD : S_WB_WAIT;
                if (wb.wb_ack_i && !we_q) tx_d = wb.wb_data_i;
            end
            S_WB_WAIT: if (wb.wb_ack_i) begin
                state_d = S_CMD;
                if (!we_q) tx_d = wb.wb_data_i;
            end
            default: state_d = S_CMD;
        endcase

        // CS high abandons a partially received command but never a bus cycle
        if (cs_high && !wb_active) state_d = S_CMD;

`ifdef SPI_WB_TIMEOUT_EN
        if (byte_done) to_flag_d = 1'b0;
        // abort at the end of the 63rd clock spent in the bus cycle
        if (wb_active && state_d != S_CMD && to_cnt_q == 6'd62) begin
            state_d   = S_CMD;
            to_flag_d = 1'b1;
            if (!we_q) tx_d = 8'hEE;
        end
        tx_bit = (bit_cnt_q == 3'd0 && to_flag_q) ? 1'b1 : tx_q[3'd7 - bit_cnt_q];
`else
        tx_bit = tx_q[3'd7 - bit_cnt_q];
`endif
        // POCI tracks the current bit whenever SCK is low, so it is settled before each rise
        poci_d = sck_q[1] ? poci_q : tx_bit;
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            state_q   <= S_CMD;
            sck_q     <= 3'b000;
            cs_q      <= 2'b11;
            pico_q    <= 2'b00;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            poci_q    <= 1'b0;
`ifdef SPI_WB_TIMEOUT_EN
            to_cnt_q  <= 6'd0;
            to_flag_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sck_q     <= sck_d;
            cs_q      <= cs_d;
            pico_q    <= pico_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            poci_q    <= poci_d;
`ifdef SPI_WB_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
`endif
        end
    end

    assign spi_poci_o     = poci_q;
    assign busy_o         = wb_active;
    assign wb.wb_cycle_o  = wb_active;
    assign wb.wb_strobe_o = (state_q == S_WB_REQ);
    assign wb.wb_we_o     = we_q;
    assign wb.wb_addr_o   = addr_q;
    assign wb.wb_data_o   = data_q;
endmodule

// File: tb/tb_spi_wb_bridge.sv
// tb/tb_spi_wb_bridge.sv - randomized self-checking bench for spi_wb_bridge against a transaction-level model
module tb_spi_wb_bridge;
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0, cs_n = 1'b1, pico = 1'b0;
    logic poci, busy;

    always #5 clk = ~clk;

    spi_wb_bridge_if #(.WB_ADDR_WIDTH(17), .DATA_WIDTH(8)) bus ();

    spi_wb_bridge #(.WB_ADDR_WIDTH(17), .DATA_WIDTH(8)) dut (
        .wb_clock_i  (clk),
        .wb_reset_n_i(rst_n),
        .spi_sck_i   (sck),
        .spi_cs_ni   (cs_n),
        .spi_pico_i  (pico),
        .spi_poci_o  (poci),
        .busy_o      (busy),
        .wb          (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // peripheral responder configuration and observed request log
    int         cfg_stall = 0, cfg_ack_delay = 0;
    bit         cfg_no_ack = 0;
    logic [7:0] cfg_rdata = 8'h00;
    logic [16:0] q_addr[$];
    logic        q_we[$];
    logic [7:0]  q_data[$];

    initial begin : responder
        bus.wb_stall_i = 1'b0;
        bus.wb_ack_i   = 1'b0;
        bus.wb_data_i  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.wb_cycle_o && bus.wb_strobe_o) begin
                q_addr.push_back(bus.wb_addr_o);
                q_we.push_back(bus.wb_we_o);
                q_data.push_back(bus.wb_data_o);
                bus.wb_stall_i = (cfg_stall != 0);
                for (int i = 0; i < cfg_stall; i++) @(negedge clk);
                bus.wb_stall_i = 1'b0;
                if (!cfg_no_ack) begin
                    for (int i = 0; i < cfg_ack_delay; i++) @(negedge clk);
                    bus.wb_ack_i  = 1'b1;
                    bus.wb_data_i = cfg_rdata;
                    @(negedge clk);
                    bus.wb_ack_i  = 1'b0;
                    bus.wb_data_i = 8'($urandom);
                end
                while (bus.wb_cycle_o) @(negedge clk);
            end
        end
    end

    // bus monitor: clocks with strobe/cycle high and any busy/cycle misbehaviour around ack
    int stb_clocks = 0, cyc_clocks = 0, busy_bad = 0;
    bit cyc_prev = 1'b0;
    always begin
        @(posedge clk);
        #2;
        if (bus.wb_ack_i && cyc_prev && (bus.wb_cycle_o || busy)) busy_bad++;
        if (busy !== bus.wb_cycle_o) busy_bad++;
        if (bus.wb_strobe_o) stb_clocks++;
        if (bus.wb_cycle_o) cyc_clocks++;
        cyc_prev = bus.wb_cycle_o;
    end

    // reference model state
    logic [16:0] m_addr = 17'h0;
    logic [7:0]  m_tx   = 8'h00;
    bit          m_flag = 1'b0;

    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            pico = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = poci;
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    // kind: 0 write-addressed, 1 read-addressed, 2 write-next, 3 read-next
    task automatic do_op(input int kind, input logic [16:0] a, input logic [7:0] d,
                         input int stall, input int delay, input bit no_ack,
                         input logic [7:0] rdata, input bit cs_between);
        logic [7:0]  b[4];
        logic [7:0]  rx;
        logic [16:0] ea;
        logic [4:0]  r5;
        int          n, s_stb, s_cyc, s_bad;
        bit          rd;
        r5 = 5'($urandom);
        rd = (kind == 1) || (kind == 3);
        cfg_stall = stall; cfg_ack_delay = delay; cfg_no_ack = no_ack; cfg_rdata = rdata;
        case (kind)
            0:       begin b[0] = {2'b00, r5[4:1], 1'b0, a[16]}; b[1] = a[15:8]; b[2] = a[7:0]; b[3] = d; n = 4; end
            1:       begin b[0] = {2'b01, r5[4:1], 1'b0, a[16]}; b[1] = a[15:8]; b[2] = a[7:0]; b[3] = 8'h00; n = 3; end
            2:       begin b[0] = {2'b10, r5, a[0]}; b[1] = d; b[2] = 8'h00; b[3] = 8'h00; n = 2; end
            default: begin b[0] = {2'b11, r5, a[0]}; b[1] = 8'h00; b[2] = 8'h00; b[3] = 8'h00; n = 1; end
        endcase
        ea = (kind < 2) ? a : m_addr + 17'd1;
        s_stb = stb_clocks; s_cyc = cyc_clocks; s_bad = busy_bad;
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            spi_xfer(b[i], rx);
            if (i == 0) begin
                check_eq("poci_byte", rx, m_flag ? (m_tx | 8'h80) : m_tx);
                m_flag = 1'b0;
            end
        end
        if (cs_between) begin
            repeat (HALF) @(negedge clk);
            cs_n = 1'b1;
        end
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        check_eq("busy_clear", busy, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("txn_count", q_addr.size(), 1);
        if (q_addr.size() != 0) begin
            check_eq("wb_addr", q_addr[0], ea);
            check_eq("wb_we", q_we[0], !rd);
            if (!rd) check_eq("wb_data", q_data[0], d);
        end
        q_addr.delete(); q_we.delete(); q_data.delete();
        check_eq("stb_clocks", stb_clocks - s_stb, stall + 1);
        check_eq("cyc_clocks", cyc_clocks - s_cyc, no_ack ? 63 : stall + 1 + delay);
        check_eq("busy_vs_ack", busy_bad - s_bad, 0);
        m_addr = ea;
        if (no_ack) begin
            m_flag = 1'b1;
            if (rd) m_tx = 8'hEE;
        end else if (rd) begin
            m_tx = rdata;
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : main
        logic [7:0] rx;
        repeat (5) @(negedge clk);
        check_eq("rst_outputs",
                 {poci, busy, bus.wb_cycle_o, bus.wb_strobe_o, bus.wb_we_o, bus.wb_addr_o, bus.wb_data_o},
                 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        do_op(0, 17'h0E810, 8'h5A, 0, 1, 0, 8'h00, 1);
        do_op(1, 17'h10002, 8'h00, 3, 0, 0, 8'hC3, 1);
        do_op(3, 17'h0, 8'h00, 1, 2, 0, 8'h71, 1);
        do_op(3, 17'h0, 8'h00, 0, 0, 0, 8'h96, 0);
        do_op(0, 17'h1FFFF, 8'hA5, 0, 1, 0, 8'h00, 1);
        do_op(2, 17'h0, 8'h3E, 2, 1, 0, 8'h00, 1);

        // partial command aborted by CS, then a full command
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 7; i >= 4; i--) begin
            pico = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        do_op(0, 17'h01234, 8'hC8, 1, 1, 0, 8'h00, 1);

        // CS raised while the cycle waits for a slow ack
        do_op(1, 17'h0BEEF, 8'h00, 0, 40, 0, 8'h3C, 1);

        for (int k = 0; k < 24; k++) begin
            do_op($urandom_range(3), 17'($urandom), 8'($urandom), $urandom_range(3),
                  $urandom_range(4), 0, 8'($urandom), 1'($urandom));
        end

`ifdef SPI_WB_TIMEOUT_EN
        do_op(1, 17'h00400, 8'h00, 0, 0, 0, 8'h3C, 1);
        do_op(0, 17'h00401, 8'h11, 1, 0, 1, 8'h00, 1);
        do_op(2, 17'h0, 8'h22, 0, 0, 0, 8'h00, 1);
        do_op(1, 17'h00500, 8'h00, 2, 0, 1, 8'h00, 1);
        do_op(0, 17'h00501, 8'h33, 0, 1, 0, 8'h00, 1);
`endif

        // asynchronous reset in the middle of a bus cycle
        cfg_stall = 0; cfg_no_ack = 1'b1;
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_xfer(8'h80, rx);
        spi_xfer(8'h6D, rx);
        for (int i = 0; i < 100 && !bus.wb_cycle_o; i++) @(negedge clk);
        check_eq("cyc_before_rst", bus.wb_cycle_o, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_mid_cycle", {busy, bus.wb_cycle_o, bus.wb_strobe_o}, 3'b000);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        q_addr.delete(); q_we.delete(); q_data.delete();
        m_addr = 17'h0; m_tx = 8'h00; m_flag = 1'b0;
        repeat (4) @(negedge clk);
        do_op(2, 17'h0, 8'h4B, 1, 0, 0, 8'h00, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_wb_bridge.md
Name: spi_wb_bridge

Overview:
- SPI target that decodes commands from the host MCU and issues single Wishbone B4 pipelined cycles.
- Sits directly upstream of the Wishbone peripherals: the register file, the RAM arbiter and the others.
- SPI signals are oversampled in the wb_clock_i domain, so no second clock domain exists.
- busy_o tells the MCU when a transaction is outstanding; the MCU must not start the next command while busy_o=1.

Parameters:
- WB_ADDR_WIDTH, 17, Wishbone address width. Bit 16 is carried in the command byte.
- DATA_WIDTH, 8, Wishbone data width. Equals the SPI byte width.

Ports:
- wb_clock_i  input  1  system clock, 64 MHz.
- wb_reset_n_i  input  1  reset; asynchronous assert, active-low.
- spi_sck_i  input  1  SPI clock, mode 0, asynchronous to wb_clock_i.
- spi_cs_ni  input  1  SPI chip select, active-low.
- spi_pico_i  input  1  SPI data, host to target.
- spi_poci_o  output  1  SPI data, target to host.
- wb_addr_o  output  WB_ADDR_WIDTH  Wishbone address.
- wb_data_o  output  DATA_WIDTH  Wishbone write data.
- wb_data_i  input  DATA_WIDTH  Wishbone read data.
- wb_we_o  output  1  Wishbone write enable.
- wb_cycle_o  output  1  Wishbone CYC.
- wb_strobe_o  output  1  Wishbone STB.
- wb_stall_i  input  1  Wishbone STALL.
- wb_ack_i  input  1  Wishbone ACK.
- busy_o  output  1  command accepted and Wishbone cycle not yet complete.

Behaviour:
- Reset values: spi_poci_o=0, wb_cycle_o=0, wb_strobe_o=0, wb_we_o=0, wb_addr_o=0, wb_data_o=0, busy_o=0. State=S_CMD; bit counter=0.
- SPI synchronisation:
  - spi_sck_i, spi_cs_ni and spi_pico_i each pass through a 2-FF synchroniser.
  - SCK rising and falling edges are detected on the synchronised copy.
  - Supported SCK is at most wb_clock_i/8.
- Shifting:
  - PICO is sampled MSB-first on synchronised SCK rise.
  - POCI is updated on synchronised SCK fall.
  - A byte completes on the 8th rise while CS is low.
- Command byte: bits[7:6]=op. 00 write-addressed, 01 read-addressed, 10 write-next, 11 read-next. Bit[0]=A16. Bits[5:1] are ignored.
- States and transitions:
  - S_CMD: latch op and A16. Next is S_ADDR_HI for addressed ops. For *-next ops, the address is incremented modulo 2^WB_ADDR_WIDTH, then next is S_DATA (write) or S_WB_REQ (read).
  - S_ADDR_HI: latch A15:8, go to S_ADDR_LO.
  - S_ADDR_LO: latch A7:0. Go to S_DATA (write) or S_WB_REQ (read).
  - S_DATA: latch the byte into wb_data_o, go to S_WB_REQ.
  - S_WB_REQ: assert cycle, strobe and busy_o, with we per op. Hold strobe while wb_stall_i=1. On the first clock with strobe=1 and stall=0, drop strobe and go to S_WB_WAIT.
  - S_WB_WAIT: hold cycle until wb_ack_i. On ack:
    - drop cycle and busy_o the same edge;
    - for reads, capture wb_data_i into the POCI shift register;
    - go to S_CMD.
  - An ack arriving in the same cycle as the strobe/stall=0 handshake is accepted, and the bridge goes directly to S_CMD.
- Read data: shifted out during the byte following the read command. The host clocks a dummy byte, which the bridge treats as the next command byte. The host must clock 0x00-free commands only after polling busy_o=0.
- CS high, or CS rising mid-byte:
  - bit counter clears;
  - a partial command is discarded and state returns to S_CMD;
  - an in-flight Wishbone cycle (S_WB_REQ/S_WB_WAIT) is never abandoned and completes normally first.
- Address register persists across CS toggles, which lets *-next ops stream.
- Bytes received while busy_o=1 are dropped.
- Asynchronous reset mid-cycle drops cycle and strobe immediately.

Optional Feature:
- Macro: SPI_WB_TIMEOUT_EN.
- With the macro: a 6-bit counter runs in S_WB_REQ/S_WB_WAIT. On reaching 63 clocks without completion, the bridge:
  - drops cycle and strobe;
  - returns to S_CMD;
  - loads 0xEE into the POCI read register for reads;
  - sets sticky timeout status, which shifts out as bit 7 of the next byte and clears when that byte ends.
- Without the macro: the bridge waits indefinitely for ack, and no counter or status logic exists.

Test Plan:
- Reset held low 5 clocks, SCK idle -> all outputs 0, busy_o=0.
- Write-addressed 0x00,0xE8,0x10,0x5A (A=0x0E810) with peripheral ack after 1 clock -> one cycle: wb_addr_o=0x0E810, wb_we_o=1, wb_data_o=0x5A, strobe high exactly 1 clock. busy_o falls on the ack edge.
- Read-addressed 0x41,0x00,0x02 with wb_stall_i=1 for 3 clocks, then wb_data_i=0xC3 with ack -> strobe held 4 clocks, wb_addr_o=0x10002, we=0. Next SPI byte returns 0xC3 on POCI.
- Read-next 0xC0 issued twice after the read above -> addresses 0x10003, then 0x10004. Then write-addressed to 0x1FFFF followed by write-next -> address wraps to 0x00000.
- CS raised after 4 bits of a command, then a full write command -> no Wishbone cycle from the partial byte. The full command executes normally. CS raised during S_WB_WAIT -> cycle still completes on ack.
- SPI_WB_TIMEOUT_EN defined, ack never given -> cycle drops after 63 clocks, busy_o=0. Next byte returns 0xEE with bit 7 set, and the status is cleared afterward.
